// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers used by both read- and write-side pointer logic.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package fifo_pkg;

    // Default FIFO address width; depth is 2**FIFO_ASIZE_DEF entries.
    localparam int FIFO_ASIZE_DEF = 4;

    // Binary to reflected Gray code. Operates on a 32-bit container so one
    // function serves every pointer width; callers truncate with a size cast.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_empty_if.sv
// Read-side pointer/flag bundle between the FIFO read port and its consumer.
// Latency: n/a (wires only).
// Backpressure: rinc is only honoured while rempty is low.
interface rd_ptr_empty_if #(
    parameter int ASIZE = 4
);
    logic             rinc;
    logic [ASIZE:0]   rq2_wptr;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   rcount;
    logic             rerr_underflow;

    // Consumer / stimulus side.
    modport master (
        output rinc,
        output rq2_wptr,
        input  raddr,
        input  rptr,
        input  rempty,
        input  ralmost_empty,
        input  rcount,
        input  rerr_underflow
    );

    // Read-pointer logic side.
    modport slave (
        input  rinc,
        input  rq2_wptr,
        output raddr,
        output rptr,
        output rempty,
        output ralmost_empty,
        output rcount,
        output rerr_underflow
    );
endinterface

// File: rtl/rd_ptr_empty_gray2bin.sv
// Gray-to-binary converter, combinational XOR prefix from the MSB down.
// Latency: 0 cycles (combinational).
// Backpressure: none.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Bit i of the binary value is the parity of Gray bits [W-1:i].
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/rd_ptr_empty.sv
// Async-FIFO read pointer: binary/Gray read pointer, empty/almost-empty, occupancy, sticky underflow.
// Latency: an accepted read at edge n is visible on raddr/rptr/flags/rcount right after edge n.
// Backpressure: rinc is ignored while rempty=1 (and flagged as underflow); no read is ever lost otherwise.
module rd_ptr_empty
    import fifo_pkg::*;
#(
    parameter int ASIZE     = FIFO_ASIZE_DEF,
    parameter int AE_THRESH = 2
) (
    input  logic           c_clk,
    input  logic           c_rst,
    rd_ptr_empty_if.slave  bus
);

    localparam int PW = ASIZE + 1;
    localparam logic [ASIZE:0] AE_LIM = PW'(AE_THRESH);

    logic [ASIZE:0] r_rbin;
    logic [ASIZE:0] r_rptr;
    logic           r_rempty;
    logic           r_ralmost_empty;
    logic [ASIZE:0] r_rcount;
    logic           r_rerr_underflow;

    logic           w_accept;
    logic           w_underflow;
    logic [ASIZE:0] w_rbin_next;
    logic [ASIZE:0] w_rgray_next;
    logic [ASIZE:0] w_wbin;
    logic [ASIZE:0] w_rcount_next;
    logic           w_rempty_next;
    logic           w_ralmost_empty_next;

    // Synchronized write pointer back to binary for the occupancy subtraction.
    gray2bin #(
        .W (PW)
    ) u_wptr_g2b (
        .i_gray (bus.rq2_wptr),
        .o_bin  (w_wbin)
    );

    // Next-state pointer, flags and count; flags are computed from the
    // post-increment pointer so they are correct on the same edge as the read.
    always_comb begin
        w_accept             = bus.rinc & ~r_rempty;
        w_underflow          = bus.rinc & r_rempty;
        w_rbin_next          = r_rbin + PW'(w_accept);
        w_rgray_next         = PW'(bin2gray(32'(w_rbin_next)));
        w_rempty_next        = (w_rgray_next == bus.rq2_wptr);
        w_rcount_next        = w_wbin - w_rbin_next;
        // Empty forces almost-empty even if a corrupted write pointer upsets the count.
        w_ralmost_empty_next = (w_rcount_next <= AE_LIM) | w_rempty_next;
    end

    // Pointer, flag and count registers; synchronous reset discards any read in flight.
    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            r_rbin           <= '0;
            r_rptr           <= '0;
            r_rempty         <= 1'b1;
            r_ralmost_empty  <= 1'b1;
            r_rcount         <= '0;
            r_rerr_underflow <= 1'b0;
        end else begin
            r_rbin           <= w_rbin_next;
            r_rptr           <= w_rgray_next;
            r_rempty         <= w_rempty_next;
            r_ralmost_empty  <= w_ralmost_empty_next;
            r_rcount         <= w_rcount_next;
            r_rerr_underflow <= r_rerr_underflow | w_underflow;
        end
    end

    assign bus.raddr          = r_rbin[ASIZE-1:0];
    assign bus.rptr           = r_rptr;
    assign bus.rempty         = r_rempty;
    assign bus.ralmost_empty  = r_ralmost_empty;
    assign bus.rcount         = r_rcount;
    assign bus.rerr_underflow = r_rerr_underflow;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Directed bench for rd_ptr_empty with ASIZE=4, AE_THRESH=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stimulus never relies on DUT readiness; every step is a fixed edge.
module tb_rd_ptr_empty;

    logic c_clk;
    logic c_rst;

    int n_checks;
    int n_fail;

    rd_ptr_empty_if #(.ASIZE(4)) bus ();

    rd_ptr_empty #(
        .ASIZE     (4),
        .AE_THRESH (2)
    ) dut (
        .c_clk (c_clk),
        .c_rst (c_rst),
        .bus   (bus.slave)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset
        c_rst        = 1'b1;
        bus.rinc     = 1'b0;
        bus.rq2_wptr = 5'b00000;
        step();
        c_rst = 1'b0;
        chk("rst_rptr",   32'(bus.rptr),           0);
        chk("rst_raddr",  32'(bus.raddr),          0);
        chk("rst_rempty", 32'(bus.rempty),         1);
        chk("rst_ae",     32'(bus.ralmost_empty),  1);
        chk("rst_rcount", 32'(bus.rcount),         0);
        chk("rst_err",    32'(bus.rerr_underflow), 0);

        // Fill: write pointer Gray 00010 = binary 3
        bus.rq2_wptr = 5'b00010;
        step();
        chk("fill_rempty", 32'(bus.rempty),        0);
        chk("fill_rcount", 32'(bus.rcount),        3);
        chk("fill_ae",     32'(bus.ralmost_empty), 0);

        // Drain three entries
        bus.rinc = 1'b1;
        step();
        chk("rd1_raddr",  32'(bus.raddr),         1);
        chk("rd1_rcount", 32'(bus.rcount),        2);
        chk("rd1_ae",     32'(bus.ralmost_empty), 1);
        chk("rd1_rempty", 32'(bus.rempty),        0);
        step();
        chk("rd2_raddr",  32'(bus.raddr),  2);
        chk("rd2_rcount", 32'(bus.rcount), 1);
        step();
        chk("rd3_raddr",  32'(bus.raddr),  3);
        chk("rd3_rcount", 32'(bus.rcount), 0);
        chk("rd3_rempty", 32'(bus.rempty), 1);
        chk("rd3_rptr",   32'(bus.rptr),   32'b00010);

        // Underflow: rinc still high while empty
        step();
        chk("uf_rptr",  32'(bus.rptr),           32'b00010);
        chk("uf_raddr", 32'(bus.raddr),          3);
        chk("uf_err",   32'(bus.rerr_underflow), 1);
        bus.rinc = 1'b0;
        step();
        chk("uf_sticky1", 32'(bus.rerr_underflow), 1);
        step();
        chk("uf_sticky2", 32'(bus.rerr_underflow), 1);

        // Reset overrides a concurrent read request
        c_rst    = 1'b1;
        bus.rinc = 1'b1;
        step();
        c_rst    = 1'b0;
        bus.rinc = 1'b0;
        chk("mrst_err",    32'(bus.rerr_underflow), 0);
        chk("mrst_raddr",  32'(bus.raddr),          0);
        chk("mrst_rptr",   32'(bus.rptr),           0);
        chk("mrst_rempty", 32'(bus.rempty),         1);
        chk("mrst_rcount", 32'(bus.rcount),         0);

        // Full: write pointer Gray 11000 = binary 16
        bus.rq2_wptr = 5'b11000;
        step();
        chk("full_rcount", 32'(bus.rcount),        16);
        chk("full_rempty", 32'(bus.rempty),        0);
        chk("full_ae",     32'(bus.ralmost_empty), 0);

        // Read all 16 entries
        bus.rinc = 1'b1;
        for (int i = 0; i < 16; i++) step();
        bus.rinc = 1'b0;
        chk("r16_raddr",  32'(bus.raddr),  0);
        chk("r16_rptr",   32'(bus.rptr),   32'b11000);
        chk("r16_rcount", 32'(bus.rcount), 0);
        chk("r16_rempty", 32'(bus.rempty), 1);

        // Advance write pointer to binary 31 (Gray 10000), read 15 more
        bus.rq2_wptr = 5'b10000;
        step();
        chk("w31_rcount", 32'(bus.rcount), 15);
        bus.rinc = 1'b1;
        for (int i = 0; i < 15; i++) step();
        bus.rinc = 1'b0;
        chk("r31_rptr",   32'(bus.rptr),   32'b10000);
        chk("r31_raddr",  32'(bus.raddr),  15);
        chk("r31_rempty", 32'(bus.rempty), 1);

        // Wrap: write pointer wraps to 0, one entry outstanding
        bus.rq2_wptr = 5'b00000;
        step();
        chk("wrap_pre_rempty", 32'(bus.rempty), 0);
        chk("wrap_pre_rcount", 32'(bus.rcount), 1);
        bus.rinc = 1'b1;
        step();
        bus.rinc = 1'b0;
        chk("wrap_rptr",   32'(bus.rptr),           0);
        chk("wrap_raddr",  32'(bus.raddr),          0);
        chk("wrap_rempty", 32'(bus.rempty),         1);
        chk("wrap_rcount", 32'(bus.rcount),         0);
        chk("wrap_err",    32'(bus.rerr_underflow), 0);

        // Simultaneous read and write-pointer advance
        bus.rq2_wptr = 5'b00001;
        step();
        chk("sim_pre_rcount", 32'(bus.rcount), 1);
        bus.rinc     = 1'b1;
        bus.rq2_wptr = 5'b00011;
        step();
        bus.rinc = 1'b0;
        chk("sim_rcount", 32'(bus.rcount), 1);
        chk("sim_rempty", 32'(bus.rempty), 0);
        chk("sim_raddr",  32'(bus.raddr),  1);
        chk("sim_rptr",   32'(bus.rptr),   32'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_ptr_empty.md
RD_PTR_EMPTY -- requirements
Module: rd_ptr_empty

Interface
REQ-001 Parameter ASIZE SHALL be: ASIZE, default 4, FIFO address width (depth 2^ASIZE).
REQ-002 Parameter AE_THRESH SHALL be: AE_THRESH, default 2, almost-empty occupancy threshold.
REQ-003 Port SHALL be: c_clk  input  1  read-domain clock, all logic on rising edge.
REQ-004 Port SHALL be: c_rst  input  1  reset, synchronous, active-high.
REQ-005 Port SHALL be: rinc  input  1  read request, one entry per cycle when asserted.
REQ-006 Port SHALL be: rq2_wptr  input  ASIZE+1  Gray-coded write pointer, already synchronized into c_clk domain.
REQ-007 Port SHALL be: raddr  output  ASIZE  binary read address to FIFO memory.
REQ-008 Port SHALL be: rptr  output  ASIZE+1  registered Gray read pointer, fed to write-side synchronizer.
REQ-009 Port SHALL be: rempty  output  1  registered empty flag.
REQ-010 Port SHALL be: ralmost_empty  output  1  registered, occupancy <= AE_THRESH.
REQ-011 Port SHALL be: rcount  output  ASIZE+1  registered occupancy, range 0..2^ASIZE.
REQ-012 Port SHALL be: rerr_underflow  output  1  sticky underflow error.

Function
REQ-013 Internal binary pointer rbin (ASIZE+1 bits) SHALL advance by 1 at a rising edge only when rinc=1 and rempty=0 (accepted read).
REQ-014 rbin SHALL wrap modulo 2^(ASIZE+1); 2^(ASIZE+1)-1 -> 0 with no other side effect.
REQ-015 rptr SHALL equal gray(rbin) = (rbin>>1)^rbin, registered, updating on the same edge as rbin.
REQ-016 raddr SHALL equal rbin[ASIZE-1:0].
REQ-017 Latency: accepted read at edge n SHALL show new raddr/rptr/rempty/rcount after edge n.
REQ-018 rempty SHALL be registered from gray(rbin_next) == rq2_wptr, rbin_next the post-increment value.
REQ-019 rcount SHALL be registered as (gray2bin(rq2_wptr) - rbin_next) mod 2^(ASIZE+1).
REQ-020 ralmost_empty SHALL be registered as (rcount_next <= AE_THRESH); rempty=1 implies ralmost_empty=1.
REQ-021 rinc=1 while rempty=1 SHALL leave rbin unchanged and set rerr_underflow=1 at that edge.
REQ-022 rerr_underflow SHALL remain 1 until reset; no other clear path.
REQ-023 rq2_wptr change coincident with accepted read SHALL both apply in the same edge's flag/count computation.
REQ-024 rcount SHALL reach 2^ASIZE (full) without overflow; values above 2^ASIZE indicate upstream fault and need no defined handling.

Reset
REQ-025 At c_clk edge with c_rst=1: rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rcount=0, rerr_underflow=0.
REQ-026 c_rst SHALL override rinc in the same cycle; reset mid-operation discards the read position.
REQ-027 No asynchronous reset path SHALL exist.

Structure
REQ-028 Shared package fifo_pkg SHALL hold bin2gray/gray2bin functions and default ASIZE constant, shared with write-side logic.
REQ-029 One sub-module gray2bin (parameterized width, combinational XOR prefix) SHALL convert rq2_wptr.
REQ-030 All outputs SHALL be driven directly from flops except raddr (flop slice).

Verification (ASIZE=4, AE_THRESH=2)
REQ-031 Reset: c_rst=1 one cycle -> rptr=0, raddr=0, rempty=1, ralmost_empty=1, rcount=0, rerr_underflow=0.
REQ-032 Fill/drain: rq2_wptr=5'b00010 (bin 3) -> next cycle rempty=0, rcount=3, ralmost_empty=0; three rinc -> raddr 1,2,3, rcount 2,1,0, rempty=1 after third.
REQ-033 Underflow: rinc=1 while empty -> rptr unchanged, rerr_underflow=1, stays 1 after rinc drops until c_rst.
REQ-034 Wrap: rbin at 31 (rptr=5'b10000), rq2_wptr=gray(0)=0 made non-empty by prior write -> read gives rbin=0, rptr=0, raddr=0.
REQ-035 Full: rbin=0, rq2_wptr=5'b11000 (bin 16) -> rcount=16, rempty=0, ralmost_empty=0.
REQ-036 Simultaneous: rcount=1, rinc=1 with rq2_wptr advancing by 1 same cycle -> rcount=1, rempty=0 next cycle.
